// File: rtl/sync_fifo_th_if.sv
// Bus bundle for sync_fifo_th: push/pop handshake, thresholds and status.
// The producer/consumer side takes the master modport and the FIFO takes the slave modport.
interface sync_fifo_th_if #(
    parameter int W  = 8,
    parameter int DP = 4
) ();
    localparam int CW = $clog2(DP + 1);

    logic          flush;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [CW-1:0] afull_th;
    logic [CW-1:0] aempty_th;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en, afull_th, aempty_th,
        input  rd_data, rd_valid, full, empty, afull, aempty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, afull_th, aempty_th,
        output rd_data, rd_valid, full, empty, afull, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_th.sv
// Single-clock FIFO of any depth 2..1024 with occupancy count, runtime thresholds,
// sticky overflow/underflow, synchronous flush and FWFT or registered read.
module sync_fifo_th #(
    parameter int W       = 8,
    parameter int DP      = 4,
    parameter int RD_FAST = 1
) (
    input  logic         clk,
    input  logic         reset,
    sync_fifo_th_if.slave bus
);
    localparam int CW = $clog2(DP + 1);
    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DP);

    if (DP < 2 || DP > 1024) begin : g_bad_depth
        $error("sync_fifo_th: DP=%0d outside 2..1024", DP);
    end

    logic [W-1:0]  mem_q [DP];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_acc, pop_acc;

    // Explicit wrap so non-power-of-two depths never alias.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        push_acc = bus.wr_en && !full_q  && !bus.flush;
        pop_acc  = bus.rd_en && !empty_q && !bus.flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push_acc) - CW'(pop_acc);
            if (bus.wr_en && full_q)  ovf_d = 1'b1;
            if (bus.rd_en && empty_q) unf_d = 1'b1;
        end
        // Status is registered from next-count so it moves with the pointers.
        full_d   = (count_d == CNT_MAX);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= bus.afull_th);
        aempty_d = (count_d <= bus.aempty_th);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; a write landing during reset is unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    if (RD_FAST != 0) begin : g_fwft
        assign bus.rd_data  = mem_q[rd_ptr_q];
        assign bus.rd_valid = 1'b0;
    end else begin : g_rdreg
        logic [W-1:0] rd_data_q;
        logic         rd_valid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= pop_acc;
                if (pop_acc) rd_data_q <= mem_q[rd_ptr_q];
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.afull     = afull_q;
    assign bus.aempty    = aempty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_sync_fifo_th.sv
// Directed bench for sync_fifo_th: one FWFT instance and one registered-read instance, DP=5, W=8.
module tb_sync_fifo_th;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_th_if #(.W(8), .DP(5)) f_if ();
    sync_fifo_th_if #(.W(8), .DP(5)) r_if ();

    sync_fifo_th #(.W(8), .DP(5), .RD_FAST(1)) u_fast (.clk(clk), .reset(reset), .bus(f_if));
    sync_fifo_th #(.W(8), .DP(5), .RD_FAST(0)) u_reg  (.clk(clk), .reset(reset), .bus(r_if));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic f_push(input logic [7:0] d);
        f_if.wr_en = 1'b1; f_if.wr_data = d;
        step();
        f_if.wr_en = 1'b0;
    endtask

    task automatic r_push(input logic [7:0] d);
        r_if.wr_en = 1'b1; r_if.wr_data = d;
        step();
        r_if.wr_en = 1'b0;
    endtask

    initial begin
        f_if.flush = 0; f_if.wr_en = 0; f_if.wr_data = 0; f_if.rd_en = 0;
        f_if.afull_th = 3'd4; f_if.aempty_th = 3'd0;
        r_if.flush = 0; r_if.wr_en = 0; r_if.wr_data = 0; r_if.rd_en = 0;
        r_if.afull_th = 3'd5; r_if.aempty_th = 3'd0;

        // reset state
        step(); step();
        chk("rst_count",  32'(f_if.count), 0);
        chk("rst_empty",  32'(f_if.empty), 1);
        chk("rst_full",   32'(f_if.full), 0);
        chk("rst_afull",  32'(f_if.afull), 0);
        chk("rst_aempty", 32'(f_if.aempty), 1);
        chk("rst_ovf",    32'(f_if.overflow), 0);
        chk("rst_unf",    32'(f_if.underflow), 0);
        chk("rst_fvalid", 32'(f_if.rd_valid), 0);
        chk("rst_rdata",  32'(r_if.rd_data), 0);
        chk("rst_rvalid", 32'(r_if.rd_valid), 0);
        reset = 1'b0;
        step();
        chk("rel_afull",  32'(f_if.afull), 0);
        chk("rel_aempty", 32'(f_if.aempty), 1);

        // fill with 0x11..0x55, then drain in order
        for (int i = 0; i < 5; i++) f_push(8'((i + 1) * 17));
        chk("t1_full",  32'(f_if.full), 1);
        chk("t1_count", 32'(f_if.count), 5);
        chk("t1_afull", 32'(f_if.afull), 1);
        for (int i = 0; i < 5; i++) begin
            chk("t1_data", 32'(f_if.rd_data), 32'((i + 1) * 17));
            f_if.rd_en = 1'b1; step(); f_if.rd_en = 1'b0;
        end
        chk("t1_empty", 32'(f_if.empty), 1);
        chk("t1_count0", 32'(f_if.count), 0);

        // 12 interleaved push/pop pairs: both pointers wrap twice
        for (int i = 0; i < 12; i++) begin
            f_push(8'(i * 7 + 3));
            chk("t2_count1", 32'(f_if.count), 1);
            chk("t2_data",   32'(f_if.rd_data), 32'(i * 7 + 3));
            f_if.rd_en = 1'b1; step(); f_if.rd_en = 1'b0;
            chk("t2_count0", 32'(f_if.count), 0);
        end
        chk("t2_ovf", 32'(f_if.overflow), 0);
        chk("t2_unf", 32'(f_if.underflow), 0);

        // overflow on full, underflow on empty
        for (int i = 0; i < 5; i++) f_push(8'(i + 1));
        f_push(8'hAA);
        chk("t3_ovf",   32'(f_if.overflow), 1);
        chk("t3_count", 32'(f_if.count), 5);
        chk("t3_full",  32'(f_if.full), 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_data", 32'(f_if.rd_data), 32'(i + 1));
            f_if.rd_en = 1'b1; step(); f_if.rd_en = 1'b0;
        end
        chk("t3_empty", 32'(f_if.empty), 1);
        f_if.rd_en = 1'b1; step(); f_if.rd_en = 1'b0;
        chk("t3_unf",     32'(f_if.underflow), 1);
        chk("t3_count0",  32'(f_if.count), 0);
        chk("t3_ovfhold", 32'(f_if.overflow), 1);
        f_if.flush = 1'b1; step(); f_if.flush = 1'b0;
        chk("fl_ovf", 32'(f_if.overflow), 0);
        chk("fl_unf", 32'(f_if.underflow), 0);

        // full with simultaneous push and pop: only the pop is taken
        for (int i = 0; i < 5; i++) f_push(8'(8'h61 + i));
        f_if.wr_en = 1'b1; f_if.rd_en = 1'b1; f_if.wr_data = 8'hBB;
        step();
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
        chk("t4_count", 32'(f_if.count), 4);
        chk("t4_ovf",   32'(f_if.overflow), 1);
        chk("t4_full",  32'(f_if.full), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_data", 32'(f_if.rd_data), 32'(8'h62 + i));
            f_if.rd_en = 1'b1; step(); f_if.rd_en = 1'b0;
        end
        chk("t4_empty", 32'(f_if.empty), 1);
        f_if.flush = 1'b1; step(); f_if.flush = 1'b0;

        // thresholds
        f_if.afull_th = 3'd3; f_if.aempty_th = 3'd1;
        step();
        chk("t5_af0", 32'(f_if.afull), 0);
        chk("t5_ae0", 32'(f_if.aempty), 1);
        f_push(8'hD1);
        chk("t5_af1", 32'(f_if.afull), 0);
        chk("t5_ae1", 32'(f_if.aempty), 1);
        f_push(8'hD2);
        chk("t5_af2", 32'(f_if.afull), 0);
        chk("t5_ae2", 32'(f_if.aempty), 0);
        f_push(8'hD3);
        chk("t5_af3", 32'(f_if.afull), 1);
        chk("t5_ae3", 32'(f_if.aempty), 0);
        f_if.rd_en = 1'b1; step(); f_if.rd_en = 1'b0;
        chk("t5_pop_ae2", 32'(f_if.aempty), 0);
        chk("t5_pop_af2", 32'(f_if.afull), 0);
        f_if.rd_en = 1'b1; step(); f_if.rd_en = 1'b0;
        chk("t5_pop_ae1", 32'(f_if.aempty), 1);
        chk("t5_pop_cnt", 32'(f_if.count), 1);
        f_if.afull_th = 3'd1;
        chk("t5_retgt_before", 32'(f_if.afull), 0);
        step();
        chk("t5_retgt_after", 32'(f_if.afull), 1);

        // threshold extremes: afull_th=0, aempty_th>=DP
        f_if.afull_th = 3'd0; f_if.aempty_th = 3'd5;
        f_if.flush = 1'b1; step(); f_if.flush = 1'b0;
        chk("bd_fl_afull",  32'(f_if.afull), 1);
        chk("bd_fl_aempty", 32'(f_if.aempty), 1);
        chk("bd_fl_count",  32'(f_if.count), 0);
        for (int i = 0; i < 5; i++) f_push(8'(8'hC0 + i));
        chk("bd_full",   32'(f_if.full), 1);
        chk("bd_aempty", 32'(f_if.aempty), 1);

        // reset in the middle of a write burst
        f_if.wr_en = 1'b1; f_if.wr_data = 8'h77;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mr_count",  32'(f_if.count), 0);
        chk("mr_empty",  32'(f_if.empty), 1);
        chk("mr_full",   32'(f_if.full), 0);
        chk("mr_afull",  32'(f_if.afull), 0);
        chk("mr_ovf",    32'(f_if.overflow), 0);
        f_if.wr_en = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("mr_rel_afull", 32'(f_if.afull), 1);
        f_push(8'h99);
        chk("mr_data",  32'(f_if.rd_data), 32'h99);
        chk("mr_count1", 32'(f_if.count), 1);

        // registered read mode
        r_if.rd_en = 1'b1; step(); r_if.rd_en = 1'b0;
        chk("r_unf",    32'(r_if.underflow), 1);
        chk("r_novalid", 32'(r_if.rd_valid), 0);
        r_push(8'h31); r_push(8'h32); r_push(8'h33);
        chk("r_count3", 32'(r_if.count), 3);
        r_if.rd_en = 1'b1; step(); r_if.rd_en = 1'b0;
        chk("r_valid",  32'(r_if.rd_valid), 1);
        chk("r_data",   32'(r_if.rd_data), 32'h31);
        chk("r_count2", 32'(r_if.count), 2);
        step();
        chk("r_valid_drop", 32'(r_if.rd_valid), 0);
        chk("r_data_hold",  32'(r_if.rd_data), 32'h31);
        r_push(8'h34);
        chk("r_count3b", 32'(r_if.count), 3);
        r_if.flush = 1'b1; r_if.wr_en = 1'b1; r_if.rd_en = 1'b1; r_if.wr_data = 8'h55;
        step();
        r_if.flush = 1'b0; r_if.wr_en = 1'b0; r_if.rd_en = 1'b0;
        chk("r_fl_count", 32'(r_if.count), 0);
        chk("r_fl_empty", 32'(r_if.empty), 1);
        chk("r_fl_unf",   32'(r_if.underflow), 0);
        chk("r_fl_ovf",   32'(r_if.overflow), 0);
        chk("r_fl_valid", 32'(r_if.rd_valid), 0);
        chk("r_fl_afull", 32'(r_if.afull), 0);
        step();
        chk("r_fl_count_idle", 32'(r_if.count), 0);
        r_push(8'h66);
        r_if.rd_en = 1'b1; step(); r_if.rd_en = 1'b0;
        chk("r_post_data",  32'(r_if.rd_data), 32'h66);
        chk("r_post_valid", 32'(r_if.rd_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
